// File: rtl/tri_feeder.sv
// Triangle producer: walks a flat vertex memory and hands triangles to the rasterizer.
// Optional back-face culling stage enabled by TRI_FEEDER_BACKFACE_CULL_EN.
module tri_feeder #(
  parameter int NUM_TRIS    = 12,
  parameter int MEM_LATENCY = 2,
  parameter int ADDR_W      = 8
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              new_frame,
  input  logic              tri_ready,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [26:0]       mem_data,
  output logic [8:0]        vert1 [2:0],
  output logic [8:0]        vert2 [2:0],
  output logic [8:0]        vert3 [2:0],
  output logic              valid_tri,
  output logic              obj_done,
  output logic              busy,
  output logic [7:0]        tri_count
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_WAIT    = 3'd2,
    S_CULL    = 3'd3,
    S_PRESENT = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_T = ADDR_W'(NUM_TRIS - 1);

  state_t                 state_r;
  logic [ADDR_W-1:0]      t_r;
  logic [1:0]             slot_r;
  logic [MEM_LATENCY-1:0] pipe_vld_r;
  logic [1:0]             pipe_slot_r [MEM_LATENCY];
  logic [2:0][26:0]       cap_r;
  logic [2:0][26:0]       cap_next_s;
  logic                   slot2_in_s;
  logic                   last_s;

  assign slot2_in_s = pipe_vld_r[MEM_LATENCY-1] && (pipe_slot_r[MEM_LATENCY-1] == 2'd2);
  assign last_s     = (t_r == LAST_T);

  // Merge the word returning this cycle into its capture slot.
  always_comb begin
    cap_next_s = cap_r;
    if (pipe_vld_r[MEM_LATENCY-1] && (pipe_slot_r[MEM_LATENCY-1] != 2'd3)) begin
      cap_next_s[pipe_slot_r[MEM_LATENCY-1]] = mem_data;
    end else begin
      cap_next_s = cap_r;
    end
  end

`ifdef TRI_FEEDER_BACKFACE_CULL_EN
  logic signed [9:0]  dx21_s, dy31_s, dy21_s, dx31_s;
  logic signed [19:0] p1_s, p2_s;
  logic signed [20:0] area_s;
  logic               front_s;

  // Signed area of the captured triangle; positive means front-facing.
  always_comb begin
    dx21_s  = $signed({1'b0, cap_r[1][26:18]}) - $signed({1'b0, cap_r[0][26:18]});
    dx31_s  = $signed({1'b0, cap_r[2][26:18]}) - $signed({1'b0, cap_r[0][26:18]});
    dy21_s  = $signed({1'b0, cap_r[1][17:9]})  - $signed({1'b0, cap_r[0][17:9]});
    dy31_s  = $signed({1'b0, cap_r[2][17:9]})  - $signed({1'b0, cap_r[0][17:9]});
    p1_s    = dx21_s * dy31_s;
    p2_s    = dy21_s * dx31_s;
    area_s  = $signed({p1_s[19], p1_s}) - $signed({p2_s[19], p2_s});
    front_s = !area_s[20] && (area_s != 21'sd0);
  end
`endif

  // Read-tag pipe tracking outstanding reads, and the capture registers it feeds.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      pipe_vld_r <= {MEM_LATENCY{1'b0}};
      for (int i = 0; i < MEM_LATENCY; i++) pipe_slot_r[i] <= 2'd0;
      cap_r <= {81{1'b0}};
    end else begin
      pipe_vld_r[0]  <= (state_r == S_FETCH);
      pipe_slot_r[0] <= slot_r;
      for (int i = 1; i < MEM_LATENCY; i++) begin
        pipe_vld_r[i]  <= pipe_vld_r[i-1];
        pipe_slot_r[i] <= pipe_slot_r[i-1];
      end
      cap_r <= cap_next_s;
    end
  end

  // Frame sequencer with registered handshake and status outputs.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_r   <= S_IDLE;
      mem_addr  <= {ADDR_W{1'b0}};
      t_r       <= {ADDR_W{1'b0}};
      slot_r    <= 2'd0;
      valid_tri <= 1'b0;
      obj_done  <= 1'b0;
      busy      <= 1'b0;
      tri_count <= 8'd0;
      vert1     <= '{default: 9'd0};
      vert2     <= '{default: 9'd0};
      vert3     <= '{default: 9'd0};
    end else begin
      obj_done <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (new_frame) begin
            t_r       <= {ADDR_W{1'b0}};
            tri_count <= 8'd0;
            busy      <= 1'b1;
            if (NUM_TRIS == 0) begin
              state_r <= S_DONE;
            end else begin
              state_r  <= S_FETCH;
              mem_addr <= {ADDR_W{1'b0}};
              slot_r   <= 2'd0;
            end
          end
        end
        S_FETCH: begin
          if (slot_r == 2'd2) begin
            slot_r  <= 2'd0;
            state_r <= S_WAIT;
          end else begin
            slot_r   <= slot_r + 2'd1;
            mem_addr <= mem_addr + ADDR_W'(1);
          end
        end
        S_WAIT: begin
          if (slot2_in_s) begin
`ifdef TRI_FEEDER_BACKFACE_CULL_EN
            state_r <= S_CULL;
`else
            state_r   <= S_PRESENT;
            valid_tri <= 1'b1;
            for (int i = 0; i < 3; i++) begin
              vert1[i] <= cap_next_s[0][9*i +: 9];
              vert2[i] <= cap_next_s[1][9*i +: 9];
              vert3[i] <= cap_next_s[2][9*i +: 9];
            end
`endif
          end
        end
`ifdef TRI_FEEDER_BACKFACE_CULL_EN
        S_CULL: begin
          if (front_s) begin
            state_r   <= S_PRESENT;
            valid_tri <= 1'b1;
            for (int i = 0; i < 3; i++) begin
              vert1[i] <= cap_r[0][9*i +: 9];
              vert2[i] <= cap_r[1][9*i +: 9];
              vert3[i] <= cap_r[2][9*i +: 9];
            end
          end else begin
            t_r <= t_r + ADDR_W'(1);
            if (last_s) begin
              state_r <= S_DONE;
            end else begin
              state_r  <= S_FETCH;
              mem_addr <= mem_addr + ADDR_W'(1);
            end
          end
        end
`endif
        S_PRESENT: begin
          if (tri_ready) begin
            valid_tri <= 1'b0;
            vert1     <= '{default: 9'd0};
            vert2     <= '{default: 9'd0};
            vert3     <= '{default: 9'd0};
            tri_count <= (tri_count == 8'hFF) ? tri_count : tri_count + 8'd1;
            t_r       <= t_r + ADDR_W'(1);
            if (last_s) begin
              state_r <= S_DONE;
            end else begin
              state_r  <= S_FETCH;
              mem_addr <= mem_addr + ADDR_W'(1);
            end
          end
        end
        S_DONE: begin
          obj_done <= 1'b1;
          busy     <= 1'b0;
          state_r  <= S_IDLE;
        end
        default: begin
          state_r <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/tri_feeder.md
Name: tri_feeder

Overview:
- Producer side of the rasterizer triangle interface.
- On each new_frame, walks a flat vertex memory holding NUM_TRIS triangles, with three consecutive words per triangle.
- Presents each triangle on vert1/vert2/vert3 with a valid_tri/tri_ready handshake.
- Pulses obj_done after the last triangle, so the rasterizer swaps its frame buffers.

Parameters:
- NUM_TRIS, 12, number of triangles in the object (12 = cube).
- MEM_LATENCY, 2, cycles from mem_addr to valid mem_data (>=1).
- ADDR_W, 8, vertex memory address width; must satisfy 2^ADDR_W >= 3*NUM_TRIS.

Ports:
- clk_in  in  1  system clock.
- rst_in  in  1  asynchronous, active-low reset.
- new_frame  in  1  one-cycle start pulse.
- tri_ready  in  1  rasterizer can accept a triangle this cycle.
- mem_addr  out  ADDR_W  vertex memory read address.
- mem_data  in  27  vertex word: [26:18]=x, [17:9]=y, [8:0]=z.
- vert1  out  [8:0] x3 (unpacked [2:0])  index 2=x, 1=y, 0=z.
- vert2  out  [8:0] x3  same layout as vert1.
- vert3  out  [8:0] x3  same layout as vert1.
- valid_tri  out  1  triangle on vert1..3 is valid.
- obj_done  out  1  one-cycle pulse, whole object sent.
- busy  out  1  high from start until obj_done.
- tri_count  out  8  triangles handed off this frame.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE.
  - mem_addr=0, vert1..3=0, valid_tri=0, obj_done=0, busy=0, tri_count=0, tri index t=0.
  - Reset mid-frame abandons the frame; no obj_done is produced.
- States: IDLE, FETCH, WAIT, CULL (macro only), PRESENT, DONE.
- IDLE:
  - new_frame=1 -> t=0, tri_count=0, busy=1, go to FETCH.
  - If NUM_TRIS==0, go straight to DONE instead.
  - new_frame outside IDLE is ignored. No queuing.
- FETCH: three cycles, driving mem_addr = 3t, 3t+1, 3t+2 in that order. Then go to WAIT.
- Capture:
  - A MEM_LATENCY-deep tag pipe (valid + slot 0/1/2) tracks each issued read.
  - The word returning for slot k is split into x/y/z and loaded into vert(k+1).
  - vert1..3 are internal capture registers; they are only visible while valid_tri=1.
- WAIT: exits when the slot-2 word is captured. Next state is CULL if enabled, else PRESENT.
- Fetch latency: first mem_addr to PRESENT entry is 3+MEM_LATENCY cycles (+1 with CULL).
- PRESENT:
  - valid_tri=1; vert1..3 held stable until handshake.
  - Transfer happens on the cycle valid_tri & tri_ready.
  - On transfer: valid_tri drops next cycle, tri_count+1, t+1.
  - If t was NUM_TRIS-1, go to DONE; else go to FETCH.
  - valid_tri never drops without a transfer.
- DONE: obj_done=1 for exactly one cycle, busy=0, then IDLE.
  - new_frame in the DONE cycle is ignored.
  - new_frame in the following IDLE cycle is accepted.
- tri_count saturates at 255.
- t is compared against NUM_TRIS-1 at full width; there is no wrap.

Optional Feature:
- Macro: TRI_FEEDER_BACKFACE_CULL_EN.
- Defined: the CULL state adds one cycle after WAIT.
  - Computes signed area A = (x2-x1)*(y3-y1) - (y2-y1)*(x3-x1).
  - Width rules: 10-bit signed differences, 20-bit products, 21-bit result.
  - A<=0 (back-facing or degenerate): triangle is skipped. No valid_tri, t+1, tri_count unchanged.
  - After a skip: go to DONE if it was the last triangle, else FETCH.
  - A>0: go to PRESENT.
- Undefined: no CULL state; every triangle is presented.

Test Plan:
- Basic frame:
  - Stimulus: NUM_TRIS=2, MEM_LATENCY=2, memory word0={x=10,y=20,z=5}, tri_ready=1 always, new_frame pulse.
  - Required: mem_addr sequence 0,1,2 then 3,4,5; valid_tri first asserts 5 cycles after the mem_addr=0 cycle; vert1 = {10,20,5}; obj_done pulses once; tri_count=2.
- Backpressure:
  - Stimulus: tri_ready=0 for 7 cycles while valid_tri=1.
  - Required: vert1..3 and valid_tri stable throughout; transfer on the first ready cycle; tri_count increments exactly once.
- Ignored start:
  - Stimulus: new_frame pulsed while busy=1.
  - Required: no restart, exactly one obj_done; a new_frame one cycle after obj_done starts a second frame.
- Async reset mid-PRESENT:
  - Stimulus: rst_in driven low while valid_tri=1.
  - Required: valid_tri, busy and tri_count go to 0 immediately; no obj_done; a subsequent new_frame restarts at mem_addr=0.
- NUM_TRIS=0:
  - Stimulus: new_frame pulse.
  - Required: obj_done exactly 2 cycles later; no mem_addr changes; no valid_tri.
- Culling (macro defined):
  - Stimulus: triangle (0,0),(10,0),(0,10), then its reversed winding.
  - Required: first triangle presented; second skipped with no valid_tri; tri_count=1; obj_done still pulses.
